// File: rtl/ysyx_25040109_lsu_if.sv
// Bundle of the LSU's three handshakes: execute-side input, memory request/response
// bus, and write-back output. The LSU sits on the slave modport.
interface ysyx_25040109_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd_addr;
  logic        in_reg_we;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_data;
  logic        out_reg_we;
  logic        out_err;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_result, in_wdata, in_rd_addr, in_reg_we,
    output in_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output out_valid, out_rd_addr, out_data, out_reg_we, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_result, in_wdata, in_rd_addr, in_reg_we,
    input  in_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  out_valid, out_rd_addr, out_data, out_reg_we, out_err,
    output out_ready
  );
endinterface

// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit: issues one memory access per instruction, aligns load data, passes
// non-memory results through. Define YSYX_25040109_LSU_MISALIGN_CHECK_EN to fault misaligned accesses.
module ysyx_25040109_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  ysyx_25040109_lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        is_load_q, is_load_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        reg_we_q, reg_we_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        is_load_op, is_store_op, legal_f3, misalign;
  logic [31:0] store_wdata, load_val;
  logic [3:0]  store_wmask;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign bus.in_ready      = (state_q == IDLE) && !rst;
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_rd_addr   = rd_addr_q;
  assign bus.out_data      = data_q;
  assign bus.out_reg_we    = reg_we_q;
  assign bus.out_err       = err_q;

  always_comb begin
    is_load_op  = (bus.in_opcode == 7'b0000011);
    is_store_op = (bus.in_opcode == 7'b0100011);
    if (is_load_op) legal_f3 = (bus.in_funct3 != 3'b011) && (bus.in_funct3 != 3'b110) &&
                               (bus.in_funct3 != 3'b111);
    else            legal_f3 = !bus.in_funct3[2] && (bus.in_funct3[1:0] != 2'b11);
`ifdef YSYX_25040109_LSU_MISALIGN_CHECK_EN
    misalign = ((bus.in_funct3[1:0] == 2'b01) && bus.in_result[0]) ||
               ((bus.in_funct3[1:0] == 2'b10) && (bus.in_result[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    // Store data is replicated across lanes so the memory only has to honour the strobes.
    case (bus.in_funct3[1:0])
      2'b00: begin
        store_wdata = {4{bus.in_wdata[7:0]}};
        store_wmask = 4'b0001 << bus.in_result[1:0];
      end
      2'b01: begin
        store_wdata = {2{bus.in_wdata[15:0]}};
        store_wmask = bus.in_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata = bus.in_wdata;
        store_wmask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    load_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
    load_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_val = {24'b0, load_byte};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b101:  load_val = {16'b0, load_half};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    is_load_d   = is_load_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    rd_addr_d   = rd_addr_q;
    reg_we_d    = reg_we_q;
    data_d      = data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rd_addr_d = bus.in_rd_addr;
          funct3_d  = bus.in_funct3;
          off_d     = bus.in_result[1:0];
          is_load_d = is_load_op;
          if ((is_load_op || is_store_op) && legal_f3 && !misalign) begin
            state_d     = REQ;
            mem_addr_d  = {bus.in_result[31:2], 2'b00};
            mem_wen_d   = is_store_op;
            mem_wdata_d = is_store_op ? store_wdata : 32'b0;
            mem_wmask_d = is_store_op ? store_wmask : 4'b0000;
            reg_we_d    = is_load_op && bus.in_reg_we;
            data_d      = 32'b0;
            err_d       = 1'b0;
          end else if (is_load_op || is_store_op) begin
            state_d  = DONE;
            reg_we_d = 1'b0;
            data_d   = 32'b0;
            err_d    = 1'b1;
          end else begin
            state_d  = DONE;
            reg_we_d = bus.in_reg_we;
            data_d   = bus.in_result;
            err_d    = 1'b0;
          end
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = DONE;
          data_d  = is_load_q ? load_val : 32'b0;
        end else if (cnt_q == TIMEOUT) begin
          state_d  = DONE;
          reg_we_d = 1'b0;
          data_d   = 32'b0;
          err_d    = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      is_load_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      rd_addr_q   <= '0;
      reg_we_q    <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      is_load_q   <= is_load_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      rd_addr_q   <= rd_addr_d;
      reg_we_q    <= reg_we_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Randomized bench for the LSU: a byte-level reference model predicts the memory request
// and write-back payload for every instruction, plus directed cases and a reset mid-access.
module tb_ysyx_25040109_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] lastOutData;
  logic        lastOutErr;

  ysyx_25040109_lsu_if bus ();

  ysyx_25040109_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        err;
    logic        we;
    logic [31:0] data;
  } exp_t;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: treat memory as four byte lanes and an access as `size` consecutive lanes.
  function automatic exp_t modelLsu(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [31:0] res, input logic [31:0] wd,
                                    input logic we, input logic [31:0] rdata);
    exp_t e;
    bit isLoad  = (op == 7'h03);
    bit isStore = (op == 7'h23);
    bit legal;
    bit mis;
    int size  = 1 << f3[1:0];
    int off   = int'(res[1:0]);
    int start = (off / size) * size;
    logic [31:0] val;
    legal = isLoad ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
`ifdef YSYX_25040109_LSU_MISALIGN_CHECK_EN
    mis = (off % size) != 0;
`else
    mis = 1'b0;
`endif
    e = '{req: 0, wen: 0, addr: 0, wdata: 0, wmask: 0, err: 0, we: 0, data: 0};
    if (!isLoad && !isStore) begin
      e.data = res;
      e.we   = we;
    end else if (!legal || mis) begin
      e.err = 1'b1;
    end else begin
      e.req  = 1'b1;
      e.addr = res & 32'hFFFF_FFFC;
      e.wen  = isStore;
      if (isStore) begin
        for (int j = 0; j < 4; j++) begin
          e.wdata[8*j +: 8] = wd[8*(j % size) +: 8];
          e.wmask[j] = (j >= start) && (j < start + size);
        end
      end else begin
        val = 32'b0;
        for (int k = 0; k < size; k++) val[8*k +: 8] = rdata[8*(start + k) +: 8];
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        e.data = val;
        e.we   = we;
      end
    end
    return e;
  endfunction

  // respDelay < 0 means the memory never answers and the access must time out.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                               input logic [31:0] wd, input logic [4:0] rd, input logic we,
                               input logic [31:0] rdata, input int readyDelay,
                               input int respDelay, input int holdOut);
    exp_t e;
    int acceptCycle;
    bit seen;
    e = modelLsu(op, f3, res, wd, we, rdata);
    if (e.req && respDelay < 0) begin
      e.err  = 1'b1;
      e.we   = 1'b0;
      e.data = 32'b0;
    end
    @(negedge clk);
    bus.in_opcode  = op;
    bus.in_funct3  = f3;
    bus.in_result  = res;
    bus.in_wdata   = wd;
    bus.in_rd_addr = rd;
    bus.in_reg_we  = we;
    bus.in_valid   = 1'b1;
    checkOutput("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    acceptCycle = cycle;
    if (e.req) begin
      for (int i = 0; i <= readyDelay; i++) begin
        @(negedge clk);
        checkOutput("mem_req_valid", bus.mem_req_valid, 1);
        checkOutput("mem_addr", bus.mem_addr, e.addr);
        checkOutput("mem_wen", bus.mem_wen, e.wen);
        if (e.wen) begin
          checkOutput("mem_wdata", bus.mem_wdata, e.wdata);
          checkOutput("mem_wmask", bus.mem_wmask, e.wmask);
        end
        if (i == readyDelay) bus.mem_req_ready = 1'b1;
        else @(posedge clk);
      end
      @(posedge clk);
      #1;
      bus.mem_req_ready = 1'b0;
      if (respDelay >= 0) begin
        repeat (respDelay) @(posedge clk);
        @(negedge clk);
        bus.mem_rdata      = rdata;
        bus.mem_resp_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = $urandom;
      end
    end
    seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
      else if (!e.req) checkOutput("no_mem_req", bus.mem_req_valid, 0);
    end
    checkOutput("out_valid_seen", seen, 1);
    if (seen) begin
      if (!e.req || respDelay >= 0)
        checkOutput("latency", cycle - acceptCycle, e.req ? readyDelay + respDelay + 2 : 0);
      for (int h = 0; h <= holdOut; h++) begin
        if (h > 0) @(negedge clk);
        checkOutput("out_valid", bus.out_valid, 1);
        checkOutput("out_data", bus.out_data, e.data);
        checkOutput("out_rd_addr", bus.out_rd_addr, rd);
        checkOutput("out_reg_we", bus.out_reg_we, e.we);
        checkOutput("out_err", bus.out_err, e.err);
        checkOutput("in_ready_busy", bus.in_ready, 0);
      end
      lastOutData = bus.out_data;
      lastOutErr  = bus.out_err;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_opcode = 0; bus.in_funct3 = 0; bus.in_result = 0;
    bus.in_wdata = 0; bus.in_rd_addr = 0; bus.in_reg_we = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_mem_req_valid", bus.mem_req_valid, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_out_err", bus.out_err, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_in_ready", bus.in_ready, 1);

    $display("[TB] directed cases");
    applyStimulus(7'h13, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 32'h0, 0, 0, 0);
    checkOutput("addi_const", lastOutData, 32'h0000_1234);
    applyStimulus(7'h03, 3'b000, 32'h8000_0003, 32'h0, 5'd6, 1'b1, 32'h80AA_BBCC, 0, 0, 1);
    checkOutput("lb_const", lastOutData, 32'hFFFF_FF80);
    applyStimulus(7'h03, 3'b100, 32'h8000_0003, 32'h0, 5'd6, 1'b1, 32'h80AA_BBCC, 0, 0, 0);
    checkOutput("lbu_const", lastOutData, 32'h0000_0080);
    applyStimulus(7'h23, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 5'd0, 1'b0, 32'h0, 0, 0, 0);
    applyStimulus(7'h03, 3'b010, 32'h8000_0010, 32'h0, 5'd7, 1'b1, 32'hDEAD_BEEF, 4, 0, 2);
    applyStimulus(7'h03, 3'b010, 32'h8000_0020, 32'h0, 5'd8, 1'b1, 32'h0, 0, -1, 0);
    checkOutput("timeout_err", lastOutErr, 1);
    applyStimulus(7'h03, 3'b011, 32'h8000_0000, 32'h0, 5'd9, 1'b1, 32'h0, 0, 0, 0);
    checkOutput("illegal_f3_err", lastOutErr, 1);
    applyStimulus(7'h03, 3'b010, 32'h8000_0001, 32'h0, 5'd10, 1'b1, 32'h1122_3344, 0, 0, 0);
    applyStimulus(7'h03, 3'b001, 32'h0000_0003, 32'h0, 5'd0, 1'b1, 32'h8001_7F00, 1, 1, 0);

    $display("[TB] reset during WAIT");
    @(negedge clk);
    bus.in_opcode = 7'h03; bus.in_funct3 = 3'b010; bus.in_result = 32'h8000_0040;
    bus.in_rd_addr = 5'd3; bus.in_reg_we = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk); bus.mem_req_ready = 1'b1;
    @(posedge clk); #1; bus.mem_req_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_mem_req_valid", bus.mem_req_valid, 0);
    checkOutput("midrst_mem_addr", bus.mem_addr, 0);
    checkOutput("midrst_mem_wen", bus.mem_wen, 0);
    checkOutput("midrst_out_data", bus.out_data, 0);
    checkOutput("midrst_out_rd_addr", bus.out_rd_addr, 0);
    checkOutput("midrst_out_reg_we", bus.out_reg_we, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_rdata = 32'hCAFE_F00D; bus.mem_resp_valid = 1'b1;
    @(posedge clk); #1; bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    checkOutput("late_resp_out_valid", bus.out_valid, 0);
    checkOutput("late_resp_out_data", bus.out_data, 0);
    checkOutput("late_resp_in_ready", bus.in_ready, 1);

    $display("[TB] randomized cases");
    for (int t = 0; t < 80; t++) begin
      int sel;
      logic [6:0] op;
      int respDelay;
      sel = $urandom_range(0, 9);
      if (sel < 4)      op = 7'h03;
      else if (sel < 7) op = 7'h23;
      else if (sel < 8) op = 7'h13;
      else if (sel < 9) op = 7'h33;
      else              op = 7'h37;
      respDelay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      applyStimulus(op, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
                    1'($urandom), $urandom, $urandom_range(0, 3), respDelay,
                    $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
